// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   640x480@60 VGA timing generator with framebuffer read addressing, run from
//   a 50 MHz clock with a divide-by-two pixel enable (one pixel tick = two
//   CLOCK_50 cycles, one frame = H_TOTAL x V_TOTAL ticks).
//
//   Ports
//     CLOCK_50     in   50 MHz system clock
//     RESET        in   synchronous reset, active-high
//     VGA_CLK      out  25 MHz pixel clock (the pix_en register itself)
//     pix_en       out  pixel tick strobe, high every second CLOCK_50 cycle
//     h_count      out  horizontal position, 0..H_TOTAL-1 (undelayed)
//     v_count      out  vertical position, 0..V_TOTAL-1 (undelayed)
//     mem_addr     out  framebuffer read address, aligned with h_count/v_count
//     VGA_HS       out  hsync, active-low, PIPE_DLY ticks behind the counters
//     VGA_VS       out  vsync, active-low, PIPE_DLY ticks behind the counters
//     VGA_BLANK_N  out  high in active video, PIPE_DLY ticks behind the counters
//     VGA_SYNC_N   out  constant 0 (no sync-on-green)
//     frame_start  out  one-cycle pulse on the tick at (0,0), skipped right after reset
//
//   The delayed sync/blank outputs line up with the 8-bit pixel the framebuffer
//   returns PIPE_DLY ticks after mem_addr is presented.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SCALE    = 2,
   parameter int PIPE_DLY = 2,
   parameter int ADDR_W   = 15
) (
   input  logic              CLOCK_50,
   input  logic              RESET,
   output logic              VGA_CLK,
   output logic              pix_en,
   output logic [9:0]        h_count,
   output logic [9:0]        v_count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_BLANK_N,
   output logic              VGA_SYNC_N,
   output logic              frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FB_W    = H_ACTIVE >> SCALE;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank_n;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

   function automatic sync_t raw_of(logic [9:0] h, logic [9:0] v);
      sync_t s;
      s.hs      = !((h >= HS_BEG) && (h <= HS_END));
      s.vs      = !((v >= VS_BEG) && (v <= VS_END));
      s.blank_n = (h < H_ACT) && (v < V_ACT);
      return s;
   endfunction

   // ------------------------------------------------------------------
   // Next raster position. The address register is loaded from the next
   // position so mem_addr is valid in the same ticks as h_count/v_count.
   // ------------------------------------------------------------------
   logic              h_wrap;
   logic              v_wrap;
   logic [9:0]        h_nxt;
   logic [9:0]        v_nxt;
   logic              act_nxt;
   logic [ADDR_W-1:0] addr_nxt;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      h_wrap   = (h_count == H_LAST);
      v_wrap   = (v_count == V_LAST);
      h_nxt    = h_wrap ? 10'd0 : h_count + 10'd1;
      v_nxt    = v_count;
      if (h_wrap) begin
         v_nxt = v_wrap ? 10'd0 : v_count + 10'd1;
      end
      act_nxt  = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      addr_nxt = ADDR_W'(v_nxt >> SCALE) * ADDR_W'(FB_W) + ADDR_W'(h_nxt >> SCALE);
   end

   // ------------------------------------------------------------------
   // Pixel enable, counters, address and frame marker.
   // ------------------------------------------------------------------
   logic started;   // set once the raster has wrapped past a full frame

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         pix_en      <= 1'b0;
         h_count     <= '0;
         v_count     <= '0;
         mem_addr    <= '0;
         started     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_en      <= ~pix_en;
         // Raised on the edge that makes pix_en high, so the pulse coincides
         // with the tick cycle whose counters read (0,0).
         frame_start <= ~pix_en && started && (h_count == 10'd0) && (v_count == 10'd0);
         if (pix_en) begin
            h_count <= h_nxt;
            v_count <= v_nxt;
            if (act_nxt) begin
               mem_addr <= addr_nxt;
            end
            if (h_wrap && v_wrap) begin
               started <= 1'b1;
            end
         end
      end
   end

   assign VGA_CLK    = pix_en;
   assign VGA_SYNC_N = 1'b0;

   // ------------------------------------------------------------------
   // Sync/blank delay line, advanced once per pixel tick.
   // ------------------------------------------------------------------
   sync_t sync_out;

   if (PIPE_DLY == 0) begin : g_bypass
      sync_t raw_nxt;
      assign raw_nxt = raw_of(h_nxt, v_nxt);

      // Registered from the next position so the outputs stay aligned with
      // the counters while still coming straight out of a flop.
      always_ff @(posedge CLOCK_50) begin
         if (RESET) begin
            sync_out <= SYNC_IDLE;
         end else if (pix_en) begin
            sync_out <= raw_nxt;
         end
      end
   end else begin : g_delay
      sync_t raw;
      sync_t dly_q [PIPE_DLY];

      assign raw = raw_of(h_count, v_count);

      // NOTE: the delay stages are reset to the idle pattern; a stale stage
      // would otherwise emit a sync or unblank pulse right after reset.
      always_ff @(posedge CLOCK_50) begin
         if (RESET) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
               dly_q[i] <= SYNC_IDLE;
            end
         end else if (pix_en) begin
            dly_q[0] <= raw;
            for (int i = 1; i < PIPE_DLY; i++) begin
               dly_q[i] <= dly_q[i-1];
            end
         end
      end

      assign sync_out = dly_q[PIPE_DLY-1];
   end

   assign VGA_HS      = sync_out.hs;
   assign VGA_VS      = sync_out.vs;
   assign VGA_BLANK_N = sync_out.blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Drives three generators from one clock and reset: the default 640x480
//   geometry, plus two reduced geometries (different SCALE and PIPE_DLY) whose
//   frames are short enough to run several complete frames.
//   A timing model computes every output from the number of CLOCK_50 edges
//   since reset release; directed measurements pin the model to literal values.
module tb_vga_timing_gen;

   typedef struct packed {
      int ha; int hf; int hs; int hb;
      int va; int vf; int vs; int vb;
      int sc; int dly;
   } cfg_t;

   typedef struct packed {
      bit pix; int h; int v; int addr;
      bit hs; bit vs; bit bl; bit fs;
   } exp_t;

   localparam cfg_t CFG_D0 = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, sc: 2, dly: 2};
   localparam cfg_t CFG_S3 = '{ha: 32,  hf: 4,  hs: 8,  hb: 4,  va: 16,  vf: 2,  vs: 2, vb: 3,  sc: 2, dly: 3};
   localparam cfg_t CFG_S0 = '{ha: 32,  hf: 4,  hs: 8,  hb: 4,  va: 16,  vf: 2,  vs: 2, vb: 3,  sc: 1, dly: 0};

   logic CLOCK_50 = 1'b0;
   logic RESET    = 1'b1;

   always #10 CLOCK_50 = ~CLOCK_50;

   logic d0_clk, d0_pix, d0_hs, d0_vs, d0_bl, d0_sn, d0_fs;
   logic s3_clk, s3_pix, s3_hs, s3_vs, s3_bl, s3_sn, s3_fs;
   logic s0_clk, s0_pix, s0_hs, s0_vs, s0_bl, s0_sn, s0_fs;
   logic [9:0]  d0_h, d0_v, s3_h, s3_v, s0_h, s0_v;
   logic [14:0] d0_a, s3_a, s0_a;

   vga_timing_gen dut (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .VGA_CLK(d0_clk), .pix_en(d0_pix),
      .h_count(d0_h), .v_count(d0_v), .mem_addr(d0_a), .VGA_HS(d0_hs), .VGA_VS(d0_vs),
      .VGA_BLANK_N(d0_bl), .VGA_SYNC_N(d0_sn), .frame_start(d0_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(CFG_S3.ha), .H_FP(CFG_S3.hf), .H_SYNC(CFG_S3.hs), .H_BP(CFG_S3.hb),
      .V_ACTIVE(CFG_S3.va), .V_FP(CFG_S3.vf), .V_SYNC(CFG_S3.vs), .V_BP(CFG_S3.vb),
      .SCALE(CFG_S3.sc), .PIPE_DLY(CFG_S3.dly), .ADDR_W(15)
   ) dut_s3 (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .VGA_CLK(s3_clk), .pix_en(s3_pix),
      .h_count(s3_h), .v_count(s3_v), .mem_addr(s3_a), .VGA_HS(s3_hs), .VGA_VS(s3_vs),
      .VGA_BLANK_N(s3_bl), .VGA_SYNC_N(s3_sn), .frame_start(s3_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(CFG_S0.ha), .H_FP(CFG_S0.hf), .H_SYNC(CFG_S0.hs), .H_BP(CFG_S0.hb),
      .V_ACTIVE(CFG_S0.va), .V_FP(CFG_S0.vf), .V_SYNC(CFG_S0.vs), .V_BP(CFG_S0.vb),
      .SCALE(CFG_S0.sc), .PIPE_DLY(CFG_S0.dly), .ADDR_W(15)
   ) dut_s0 (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .VGA_CLK(s0_clk), .pix_en(s0_pix),
      .h_count(s0_h), .v_count(s0_v), .mem_addr(s0_a), .VGA_HS(s0_hs), .VGA_VS(s0_vs),
      .VGA_BLANK_N(s0_bl), .VGA_SYNC_N(s0_sn), .frame_start(s0_fs)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Timing model: everything follows from c, the number of CLOCK_50 edges
   // since the last edge that sampled RESET high.
   // ------------------------------------------------------------------
   function automatic int htot(cfg_t g);
      return g.ha + g.hf + g.hs + g.hb;
   endfunction

   function automatic int vtot(cfg_t g);
      return g.va + g.vf + g.vs + g.vb;
   endfunction

   function automatic int fb_addr(cfg_t g, int h, int v);
      return (v >> g.sc) * (g.ha >> g.sc) + (h >> g.sc);
   endfunction

   // Address held at raster tick t: the last visible pixel reached so far.
   function automatic int addr_at(cfg_t g, int t);
      int h;
      int v;
      h = t % htot(g);
      v = (t / htot(g)) % vtot(g);
      if (v >= g.va) return fb_addr(g, g.ha - 1, g.va - 1);
      if (h >= g.ha) return fb_addr(g, g.ha - 1, v);
      return fb_addr(g, h, v);
   endfunction

   function automatic exp_t model(cfg_t g, int c);
      exp_t e;
      int t;
      int s;
      int sh;
      int sv;
      t      = c / 2;
      e.pix  = (c % 2) == 1;
      e.h    = t % htot(g);
      e.v    = (t / htot(g)) % vtot(g);
      e.addr = addr_at(g, t);
      if (t >= g.dly && t >= 1) begin
         s    = t - g.dly;
         sh   = s % htot(g);
         sv   = (s / htot(g)) % vtot(g);
         e.hs = !(sh >= g.ha + g.hf && sh < g.ha + g.hf + g.hs);
         e.vs = !(sv >= g.va + g.vf && sv < g.va + g.vf + g.vs);
         e.bl = (sh < g.ha) && (sv < g.va);
      end else begin
         e.hs = 1'b1;
         e.vs = 1'b1;
         e.bl = 1'b0;
      end
      e.fs = e.pix && (t > 0) && (t % (htot(g) * vtot(g)) == 0);
      return e;
   endfunction

   int c         = 0;
   bit in_rst    = 1'b1;
   bit rst_seen  = 1'b0;

   always @(posedge CLOCK_50) begin
      if (RESET) begin
         c        <= 0;
         in_rst   <= 1'b1;
         rst_seen <= 1'b1;
      end else begin
         c        <= c + 1;
         in_rst   <= 1'b0;
      end
   end

   task automatic cmp(string tag, cfg_t g, logic pix, logic vclk, logic [9:0] h, logic [9:0] v,
                      logic [14:0] a, logic hs, logic vs, logic bl, logic sn, logic fs);
      exp_t e;
      if (in_rst) e = '{pix: 1'b0, h: 0, v: 0, addr: 0, hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0};
      else        e = model(g, c);
      check({tag, ".pix_en"},      32'(pix),  32'(e.pix));
      check({tag, ".VGA_CLK"},     32'(vclk), 32'(e.pix));
      check({tag, ".h_count"},     32'(h),    e.h);
      check({tag, ".v_count"},     32'(v),    e.v);
      check({tag, ".mem_addr"},    32'(a),    e.addr);
      check({tag, ".VGA_HS"},      32'(hs),   32'(e.hs));
      check({tag, ".VGA_VS"},      32'(vs),   32'(e.vs));
      check({tag, ".VGA_BLANK_N"}, 32'(bl),   32'(e.bl));
      check({tag, ".VGA_SYNC_N"},  32'(sn),   32'd0);
      check({tag, ".frame_start"}, 32'(fs),   32'(e.fs));
   endtask

   always @(negedge CLOCK_50) begin
      if (rst_seen) begin
         cmp("d0", CFG_D0, d0_pix, d0_clk, d0_h, d0_v, d0_a, d0_hs, d0_vs, d0_bl, d0_sn, d0_fs);
         cmp("s3", CFG_S3, s3_pix, s3_clk, s3_h, s3_v, s3_a, s3_hs, s3_vs, s3_bl, s3_sn, s3_fs);
         cmp("s0", CFG_S0, s0_pix, s0_clk, s0_h, s0_v, s0_a, s0_hs, s0_vs, s0_bl, s0_sn, s0_fs);
      end
   end

   // ------------------------------------------------------------------
   // Statistics since the last reset, for the directed frame-level checks.
   // ------------------------------------------------------------------
   int fs_cnt, fs_first, fs_last, fs_period;
   int vs_lo_s3, vs_lo_s0;
   int max_h_d0, max_h_s3, max_v_s3, max_a_s3, max_a_s0;

   always @(negedge CLOCK_50) begin
      if (rst_seen) begin
         if (in_rst) begin
            fs_cnt = 0; fs_first = -1; fs_last = -1; fs_period = -1;
            vs_lo_s3 = 0; vs_lo_s0 = 0;
            max_h_d0 = 0; max_h_s3 = 0; max_v_s3 = 0; max_a_s3 = 0; max_a_s0 = 0;
         end else begin
            if (s3_fs === 1'b1) begin
               fs_cnt++;
               if (fs_first < 0) fs_first = c;
               else              fs_period = c - fs_last;
               fs_last = c;
            end
            if (s3_pix === 1'b1 && s3_vs === 1'b0) vs_lo_s3++;
            if (s0_pix === 1'b1 && s0_vs === 1'b0) vs_lo_s0++;
            if (int'(d0_h) > max_h_d0) max_h_d0 = int'(d0_h);
            if (int'(s3_h) > max_h_s3) max_h_s3 = int'(s3_h);
            if (int'(s3_v) > max_v_s3) max_v_s3 = int'(s3_v);
            if (int'(s3_a) > max_a_s3) max_a_s3 = int'(s3_a);
            if (int'(s0_a) > max_a_s0) max_a_s0 = int'(s0_a);
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed sequence.
   // ------------------------------------------------------------------
   initial begin
      int  hs_lo, hs_first, bl_hi, bl_first;
      int  a4, a639, a700, a_0_4;
      bit  found;

      // Power-on reset, three edges.
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check("rst.h_count",     32'(d0_h),  0);
      check("rst.v_count",     32'(d0_v),  0);
      check("rst.pix_en",      32'(d0_pix), 0);
      check("rst.mem_addr",    32'(d0_a),  0);
      check("rst.VGA_HS",      32'(d0_hs), 1);
      check("rst.VGA_VS",      32'(d0_vs), 1);
      check("rst.VGA_BLANK_N", 32'(d0_bl), 0);
      check("rst.frame_start", 32'(d0_fs), 0);
      #1 RESET = 1'b0;

      // First edge raises pix_en; the second edge is the first tick.
      @(negedge CLOCK_50);
      check("edge1.pix_en",  32'(d0_pix), 1);
      check("edge1.h_count", 32'(d0_h),   0);
      @(negedge CLOCK_50);
      check("edge2.pix_en",  32'(d0_pix), 0);
      check("edge2.h_count", 32'(d0_h),   1);

      // Line 0 of the default geometry.
      hs_lo = 0; hs_first = -1; bl_hi = 0; bl_first = -1;
      a4 = -1; a639 = -1; a700 = -1;
      for (int n = 0; n < 1700; n++) begin
         @(negedge CLOCK_50);
         if (d0_pix === 1'b1 && d0_v == 10'd0) begin
            if (d0_hs === 1'b0) begin
               hs_lo++;
               if (hs_first < 0) hs_first = int'(d0_h);
            end
            if (d0_bl === 1'b1) begin
               bl_hi++;
               if (bl_first < 0) bl_first = int'(d0_h);
            end
            if (d0_h == 10'd4)   a4   = int'(d0_a);
            if (d0_h == 10'd639) a639 = int'(d0_a);
            if (d0_h == 10'd700) a700 = int'(d0_a);
         end
      end
      check("line0.hs_low_ticks",   hs_lo,    96);
      check("line0.hs_first_tick",  hs_first, 658);
      check("line0.blank_hi_ticks", bl_hi,    640);
      check("line0.blank_first",    bl_first, 2);
      check("addr(4,0)",            a4,       1);
      check("addr(639,0)",          a639,     159);
      check("addr_hold(700,0)",     a700,     159);

      found = 1'b0; a_0_4 = -1;
      for (int n = 0; n < 8000 && !found; n++) begin
         @(negedge CLOCK_50);
         if (d0_h == 10'd0 && d0_v == 10'd4) begin
            found = 1'b1;
            a_0_4 = int'(d0_a);
         end
      end
      check("reach(0,4)", 32'(found), 1);
      check("addr(0,4)",  a_0_4,      160);

      // Run on to (300,5) on the default geometry, then reset mid-line.
      found = 1'b0;
      for (int n = 0; n < 4000 && !found; n++) begin
         @(negedge CLOCK_50);
         if (d0_h == 10'd300 && d0_v == 10'd5) found = 1'b1;
      end
      check("reach(300,5)", 32'(found), 1);
      #1;
      check("s3.frame_pulses",  fs_cnt,    3);
      check("s3.first_frame_c", fs_first,  2209);
      check("s3.frame_period",  fs_period, 2208);
      check("s3.max_addr",      max_a_s3,  31);
      check("s0.max_addr",      max_a_s0,  127);
      RESET = 1'b1;

      @(negedge CLOCK_50);
      check("midrst.h_count",     32'(d0_h),  0);
      check("midrst.v_count",     32'(d0_v),  0);
      check("midrst.VGA_BLANK_N", 32'(d0_bl), 0);
      repeat (2) @(negedge CLOCK_50);
      #1 RESET = 1'b0;

      // Blanking persists for PIPE_DLY ticks after release.
      @(negedge CLOCK_50);
      check("rel.tick0.blank", 32'(d0_bl), 0);
      repeat (2) @(negedge CLOCK_50);
      check("rel.tick1.blank", 32'(d0_bl), 0);
      repeat (2) @(negedge CLOCK_50);
      check("rel.tick2.blank", 32'(d0_bl), 1);

      // Just under two reduced frames after release.
      repeat (4395) @(negedge CLOCK_50);
      #1;
      check("win.s3.frame_pulses", fs_cnt,   1);
      check("win.s3.vs_low_ticks", vs_lo_s3, 192);
      check("win.s0.vs_low_ticks", vs_lo_s0, 192);
      check("win.s3.max_h",        max_h_s3, 47);
      check("win.s3.max_v",        max_v_s3, 22);
      check("win.d0.max_h",        max_h_d0, 799);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
